uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Round-robin scheduler sharing one uart_byte_tx transmitter between NUM_REQ byte producers.
//   Accepts one byte at a time from a valid/ready requester and pulses send_en to the transmitter.
//   Waits for tx_done, with a watchdog, then rotates priority.
//   Also owns the transmitter's baud_set and applies configuration changes only between bytes.
// PARAMETERS
//   NUM_REQ       4      number of requesters, 2..8
//   TIMEOUT_CYC   65535  max cycles from send_en pulse to tx_done before abort, >=2
//   BAUD_DEFAULT  3'd4   tx_baud_set after reset
// PORTS
//   clk           in   1            system clock
//   reset         in   1            synchronous, active-high reset
//   req_valid     in   NUM_REQ      requester i has a byte; held until its req_ready pulse
//   req_data      in   8*NUM_REQ    byte of requester i at [8i+7:8i]
//   req_ready     out  NUM_REQ      one-hot, 1-cycle pulse: byte of requester i was captured
//   req_done      out  NUM_REQ      one-hot, 1-cycle pulse: granted byte finished (tx_done seen)
//   timeout_err   out  1            1-cycle pulse: watchdog expired, byte abandoned
//   grant_id      out  $clog2(NUM_REQ)  index of the current or last granted requester
//   busy          out  1            high in every state except IDLE
//   cfg_baud_we   in   1            write strobe for cfg_baud
//   cfg_baud      in   3            new baud code
//   tx_data_byte  out  8            to uart_byte_tx data_byte
//   tx_send_en    out  1            to uart_byte_tx send_en, 1-cycle pulse
//   tx_baud_set   out  3            to uart_byte_tx baud_set
//   tx_done       in   1            from uart_byte_tx, 1-cycle pulse at end of frame
// BEHAVIOUR
//   Reset values: all outputs registered.
//   - req_ready, req_done, timeout_err, tx_send_en, busy, grant_id, tx_data_byte, rr pointer: 0.
//   - tx_baud_set and the pending-baud register: BAUD_DEFAULT. The pending-valid flag: 0.
//   FSM states: IDLE, LAUNCH, WAIT.
//   - IDLE -> LAUNCH: any req_valid set at a clock edge.
//     - Grant the first valid index at or after ptr, scanning upward modulo NUM_REQ.
//     - On the same edge, latch tx_data_byte <= req_data[g] and grant_id <= g.
//     - Set req_ready[g]=1 for the LAUNCH cycle only.
//   - LAUNCH: tx_send_en=1 for exactly this cycle. tx_data_byte is stable from LAUNCH until the next grant.
//     Watchdog counter cleared. Always -> WAIT.
//   - WAIT: counter increments each cycle.
//     - tx_done=1: req_done[g] pulses next cycle, ptr <= (g+1) mod NUM_REQ, -> IDLE.
//     - Else counter reaches TIMEOUT_CYC-1: timeout_err pulses next cycle, ptr advances as above, -> IDLE.
//     - tx_done in the same cycle as expiry counts as done; no error.
//   - tx_done is ignored in IDLE and LAUNCH.
//   Latency: req_valid sampled at edge t gives req_ready and tx_send_en both high during cycle t+1.
//     Minimum inter-byte spacing is 1 IDLE cycle after req_done.
//   Requester rule: after its req_ready pulse, a requester drops req_valid or presents its next byte by the following edge.
//     Valid may be raised at any time; valid never requires ready before it asserts.
//   Baud config:
//     - cfg_baud_we loads the pending register and sets the pending flag; the last write wins.
//     - In IDLE, if the pending flag is set, tx_baud_set <= pending and the flag clears.
//     - tx_baud_set never changes in LAUNCH or WAIT.
//     - A write in IDLE takes effect at the next edge. A grant on that same edge still launches with the new code.
//   Fairness: a requester holding valid is served within NUM_REQ grants.
//   Reset mid-transfer: on the next edge all state returns to reset values and the byte is abandoned.
//     No req_done or timeout_err is issued. The transmitter is reset by its own reset.
// STRUCTURE
//   Shared include uart_defs.vh:
//   - FSM state encodings.
//   - Baud codes BAUD_9600..BAUD_115200 (3'd0..3'd4).
//   - Default TIMEOUT_CYC.
//   One sub-module, uart_rr_pick: combinational masked priority pick (req vector, ptr) -> any, index.
//   FSM, watchdog counter and baud shadow stay in the top.
// TESTING (20 ns clk, behavioural uart_byte_tx model: tx_done 4340 cycles after send_en)
//   1. req_valid=0001, data0=8'hAA -> req_ready=0001 and tx_send_en=1 with tx_data_byte=8'hAA in the same cycle;
//      req_done=0001 one cycle after tx_done; grant_id=0.
//   2. All four valid at once, data 8'h11/22/33/44, held -> bytes sent 11,22,33,44, then 11 again;
//      exactly one tx_send_en per tx_done.
//   3. After requester 1 is served (ptr=2), req_valid=1010 -> requester 3 is granted before requester 1.
//   4. TIMEOUT_CYC=1000 and the model suppresses tx_done -> timeout_err pulses 1000 cycles after tx_send_en;
//      no req_done; the next grant skips to ptr+1.
//   5. cfg_baud_we with cfg_baud=3'd1 during WAIT -> tx_baud_set stays 4 until the cycle after returning to IDLE, then 1;
//      two writes (1, then 2) in WAIT -> 2 applied.
//   6. reset=1 for one cycle in WAIT -> next cycle busy=0, tx_send_en=0, ptr=0, tx_baud_set=4, no done/err pulse;
//      a later tx_done is ignored.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, baud codes,
// default watchdog length and the round-robin pointer increment.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } arb_state_e;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int TIMEOUT_CYC_DEFAULT = 65535;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: lowest-offset set bit at or after ptr,
// scanning upward modulo N.
module uart_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  // Scan from the farthest offset down so the nearest candidate is written last
  always_comb begin
    int sum;
    int cand;
    sum  = 0;
    cand = 0;
    any  = |req;
    idx  = {W{1'b0}};
    for (int off = N - 1; off >= 0; off--) begin
      sum  = int'(ptr) + off;
      cand = (sum >= N) ? sum - N : sum;
      idx  = req[cand] ? W'(cand) : idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one byte transmitter between NUM_REQ producers,
// with a tx_done watchdog and a baud shadow applied only between bytes.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter int         TIMEOUT_CYC  = TIMEOUT_CYC_DEFAULT,
  parameter logic [2:0] BAUD_DEFAULT = BAUD_115200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       timeout_err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  input  logic                       cfg_baud_we,
  input  logic [2:0]                 cfg_baud,
  output logic [7:0]                 tx_data_byte,
  output logic                       tx_send_en,
  output logic [2:0]                 tx_baud_set,
  input  logic                       tx_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e          state_r, state_next_s;
  logic [IW-1:0]       ptr_r;
  logic [CW-1:0]       cnt_r;
  logic [2:0]          pend_baud_r;
  logic                pend_v_r;
  logic                pick_any_s;
  logic [IW-1:0]       pick_idx_s;
  logic                grant_s, done_s, expire_s;
  logic [NUM_REQ-1:0]  ready_next_s, done_next_s;

  uart_rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
    .req (req_valid),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  assign grant_s  = (state_r == ST_IDLE) && pick_any_s;
  assign done_s   = (state_r == ST_WAIT) && tx_done;
  // Done in the expiry cycle wins over the watchdog
  assign expire_s = (state_r == ST_WAIT) && !tx_done && (cnt_r == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   state_next_s = pick_any_s ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: state_next_s = ST_WAIT;
      ST_WAIT:   state_next_s = (done_s || expire_s) ? ST_IDLE : ST_WAIT;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Next values of the one-hot handshake outputs
  always_comb begin
    ready_next_s = {NUM_REQ{1'b0}};
    done_next_s  = {NUM_REQ{1'b0}};
    if (grant_s) ready_next_s = ONE_HOT0 << pick_idx_s;
    else         ready_next_s = {NUM_REQ{1'b0}};
    if (done_s)  done_next_s  = ONE_HOT0 << grant_id;
    else         done_next_s  = {NUM_REQ{1'b0}};
  end

  // Registered handshake, grant datapath, pointer and watchdog counter
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready    <= {NUM_REQ{1'b0}};
      req_done     <= {NUM_REQ{1'b0}};
      timeout_err  <= 1'b0;
      tx_send_en   <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= {IW{1'b0}};
      tx_data_byte <= 8'h00;
      ptr_r        <= {IW{1'b0}};
      cnt_r        <= {CW{1'b0}};
    end else begin
      req_ready   <= ready_next_s;
      req_done    <= done_next_s;
      timeout_err <= expire_s;
      tx_send_en  <= grant_s;
      busy        <= (state_next_s != ST_IDLE);
      if (grant_s) begin
        grant_id     <= pick_idx_s;
        tx_data_byte <= req_data[{pick_idx_s, 3'b000} +: 8];
      end
      if (done_s || expire_s) ptr_r <= IW'(wrap_inc(int'(grant_id), NUM_REQ));
      // Counter holds cycles since the send_en pulse
      if (state_r == ST_IDLE) cnt_r <= {CW{1'b0}};
      else                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Baud shadow: writes in IDLE apply immediately, otherwise wait for IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_baud_set <= BAUD_DEFAULT;
      pend_baud_r <= BAUD_DEFAULT;
      pend_v_r    <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (cfg_baud_we) begin
        tx_baud_set <= cfg_baud;
        pend_baud_r <= cfg_baud;
        pend_v_r    <= 1'b0;
      end else if (pend_v_r) begin
        tx_baud_set <= pend_baud_r;
        pend_v_r    <= 1'b0;
      end
    end else if (cfg_baud_we) begin
      pend_baud_r <= cfg_baud;
      pend_v_r    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model;
// a second instance with a short watchdog exercises the timeout path.
module tb_uart_tx_arbiter;

  localparam int DLY = 4340;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic        cfg_baud_we = 1'b0;
  logic [2:0]  cfg_baud = 3'd0;
  logic        inj_done = 1'b0;
  logic        mdl_done = 1'b0;
  logic        mdl_act = 1'b0;
  int          mdl_cnt = 0;
  logic        tx_done;

  logic [3:0] req_ready, req_done;
  logic       timeout_err, busy, tx_send_en;
  logic [1:0] grant_id;
  logic [7:0] tx_data_byte;
  logic [2:0] tx_baud_set;

  logic [3:0] req_ready_b, req_done_b;
  logic       timeout_err_b, busy_b, tx_send_en_b;
  logic [1:0] grant_id_b;
  logic [7:0] tx_data_byte_b;
  logic [2:0] tx_baud_set_b;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_send = 0, n_tdone = 0, n_rdone = 0, n_err = 0, n_rdone_b = 0;

  always #10 clk = ~clk;
  assign tx_done = mdl_done | inj_done;

  uart_tx_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .timeout_err(timeout_err),
    .grant_id(grant_id), .busy(busy), .cfg_baud_we(cfg_baud_we), .cfg_baud(cfg_baud),
    .tx_data_byte(tx_data_byte), .tx_send_en(tx_send_en), .tx_baud_set(tx_baud_set),
    .tx_done(tx_done)
  );

  uart_tx_arbiter #(.TIMEOUT_CYC(1000)) dut_to (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_b), .req_done(req_done_b), .timeout_err(timeout_err_b),
    .grant_id(grant_id_b), .busy(busy_b), .cfg_baud_we(cfg_baud_we), .cfg_baud(cfg_baud),
    .tx_data_byte(tx_data_byte_b), .tx_send_en(tx_send_en_b), .tx_baud_set(tx_baud_set_b),
    .tx_done(1'b0)
  );

  // Transmitter model: tx_done pulses DLY cycles after the send_en cycle
  always @(posedge clk) begin
    if (reset) begin
      mdl_act <= 1'b0; mdl_cnt <= 0; mdl_done <= 1'b0;
    end else if (tx_send_en) begin
      mdl_act <= 1'b1; mdl_cnt <= 1; mdl_done <= 1'b0;
    end else if (mdl_act && mdl_cnt == DLY - 1) begin
      mdl_act <= 1'b0; mdl_done <= 1'b1;
    end else begin
      mdl_cnt <= mdl_cnt + 1; mdl_done <= 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_send_en)        n_send    <= n_send + 1;
    if (tx_done)           n_tdone   <= n_tdone + 1;
    if (req_done != 4'b0)  n_rdone   <= n_rdone + 1;
    if (timeout_err)       n_err     <= n_err + 1;
    if (req_done_b != 4'b0) n_rdone_b <= n_rdone_b + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic wait_ready(input int budget);
    for (int n = 0; n < budget && req_ready == 4'b0000; n++) @(negedge clk);
  endtask

  task automatic wait_send(input int budget);
    for (int n = 0; n < budget && tx_send_en == 1'b0; n++) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output logic last_td);
    last_td = 1'b0;
    for (int n = 0; n < budget && req_done == 4'b0000; n++) begin
      last_td = tx_done;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 4'b0000; cfg_baud_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_oh;
    logic [7:0] exp_byte;
    logic [1:0] exp_gid;
  } vec_t;

  vec_t vt[6];
  logic ltd;
  int   bad, bs, bd, br, be, c0;
  logic [7:0] seq[5];

  initial begin
    vt[0] = '{4'b0001, 4'b0001, 8'hAA, 2'd0};
    vt[1] = '{4'b0010, 4'b0010, 8'h22, 2'd1};
    vt[2] = '{4'b1010, 4'b1000, 8'h44, 2'd3};
    vt[3] = '{4'b0010, 4'b0010, 8'h22, 2'd1};
    vt[4] = '{4'b0101, 4'b0100, 8'h33, 2'd2};
    vt[5] = '{4'b0001, 4'b0001, 8'hAA, 2'd0};
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44; seq[4] = 8'h11;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_send", {31'd0, tx_send_en}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_gid", {30'd0, grant_id}, 32'd0);
    chk("rst_data", {24'd0, tx_data_byte}, 32'd0);
    chk("rst_baud", {29'd0, tx_baud_set}, 32'd4);
    reset = 1'b0;

    // Table: single transfers, round-robin order and wrap
    req_data = {8'h44, 8'h33, 8'h22, 8'hAA};
    for (int i = 0; i < 6; i++) begin
      req_valid = vt[i].valid;
      wait_ready(8);
      chk($sformatf("v%0d_ready", i), {28'd0, req_ready}, {28'd0, vt[i].exp_oh});
      chk($sformatf("v%0d_send", i), {31'd0, tx_send_en}, 32'd1);
      chk($sformatf("v%0d_byte", i), {24'd0, tx_data_byte}, {24'd0, vt[i].exp_byte});
      chk($sformatf("v%0d_gid", i), {30'd0, grant_id}, {30'd0, vt[i].exp_gid});
      req_valid = req_valid & ~req_ready;
      @(negedge clk);
      wait_done(DLY + 50, ltd);
      chk($sformatf("v%0d_done", i), {28'd0, req_done}, {28'd0, vt[i].exp_oh});
      chk($sformatf("v%0d_txdone_prev", i), {31'd0, ltd}, 32'd1);
      chk($sformatf("v%0d_noerr", i), {31'd0, timeout_err}, 32'd0);
    end

    // All four held: 11,22,33,44,11 with one send per tx_done
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bs = n_send; bd = n_tdone;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_send(DLY + 50);
      chk($sformatf("all_byte%0d", k), {24'd0, tx_data_byte}, {24'd0, seq[k]});
      chk($sformatf("all_gid%0d", k), {30'd0, grant_id}, k % 4);
      @(negedge clk);
    end
    wait_done(DLY + 50, ltd);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    chk("all_sends", n_send - bs, 32'd5);
    chk("all_tdones", n_tdone - bd, 32'd5);

    // Baud write during WAIT applies only after returning to IDLE (ptr=1)
    req_valid = 4'b0010;
    wait_ready(8);
    chk("baud1_gid", {30'd0, grant_id}, 32'd1);
    req_valid = 4'b0000;
    repeat (5) @(negedge clk);
    cfg_baud_we = 1'b1; cfg_baud = 3'd1;
    @(negedge clk);
    cfg_baud_we = 1'b0;
    bad = 0;
    for (int n = 0; n < DLY + 50 && req_done == 4'b0000; n++) begin
      if (tx_baud_set !== 3'd4) bad++;
      @(negedge clk);
    end
    chk("baud1_hold", bad, 32'd0);
    chk("baud1_idle_old", {29'd0, tx_baud_set}, 32'd4);
    @(negedge clk);
    chk("baud1_applied", {29'd0, tx_baud_set}, 32'd1);

    req_valid = 4'b0100;
    wait_ready(8);
    chk("baud2_gid", {30'd0, grant_id}, 32'd2);
    req_valid = 4'b0000;
    repeat (5) @(negedge clk);
    cfg_baud_we = 1'b1; cfg_baud = 3'd1;
    @(negedge clk);
    cfg_baud = 3'd2;
    @(negedge clk);
    cfg_baud_we = 1'b0;
    wait_done(DLY + 50, ltd);
    chk("baud2_idle_old", {29'd0, tx_baud_set}, 32'd1);
    @(negedge clk);
    chk("baud2_last_wins", {29'd0, tx_baud_set}, 32'd2);

    // IDLE write with simultaneous grant, then reset mid-WAIT
    req_valid = 4'b1000; cfg_baud_we = 1'b1; cfg_baud = 3'd3;
    @(negedge clk);
    chk("idlew_send", {31'd0, tx_send_en}, 32'd1);
    chk("idlew_gid", {30'd0, grant_id}, 32'd3);
    chk("idlew_baud", {29'd0, tx_baud_set}, 32'd3);
    cfg_baud_we = 1'b0; req_valid = 4'b0000;
    repeat (10) @(negedge clk);
    br = n_rdone; be = n_err;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_send", {31'd0, tx_send_en}, 32'd0);
    chk("mrst_baud", {29'd0, tx_baud_set}, 32'd4);
    chk("mrst_gid", {30'd0, grant_id}, 32'd0);
    repeat (2) @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    chk("mrst_ign_done", {28'd0, req_done}, 32'd0);
    chk("mrst_ign_busy", {31'd0, busy}, 32'd0);
    chk("mrst_no_done", n_rdone - br, 32'd0);
    chk("mrst_no_err", n_err - be, 32'd0);
    req_valid = 4'b1111;
    wait_ready(8);
    chk("mrst_ptr0", {30'd0, grant_id}, 32'd0);
    req_valid = 4'b0000;

    // Watchdog on the TIMEOUT_CYC=1000 instance
    do_reset();
    req_valid = 4'b0001;
    for (int n = 0; n < 8 && req_ready_b == 4'b0000; n++) @(negedge clk);
    chk("to_send", {31'd0, tx_send_en_b}, 32'd1);
    c0 = cyc; br = n_rdone_b;
    req_valid = 4'b0000;
    for (int n = 0; n < 1100 && timeout_err_b == 1'b0; n++) @(negedge clk);
    chk("to_err", {31'd0, timeout_err_b}, 32'd1);
    chk("to_delay", cyc - c0, 32'd1000);
    chk("to_no_done", n_rdone_b - br, 32'd0);
    chk("to_idle", {31'd0, busy_b}, 32'd0);
    req_valid = 4'b0011;
    @(negedge clk);
    chk("to_next_ready", {28'd0, req_ready_b}, 32'b0010);
    chk("to_next_gid", {30'd0, grant_id_b}, 32'd1);
    req_valid = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
